// File: rtl/imem_loader.sv
// imem_loader: runtime program loader that writes into the instruction memory.
//
// It receives a framed byte stream:
//   SYNC_BYTE, N[15:8], N[7:0], N words of 4 bytes each (MSB first), CHK.
// CHK is the XOR of all 4N data bytes.
// Words are written to consecutive word addresses, starting at 0.
// cpu_hold stays high for the whole load. It also stays high after a failed
// load, so a partial program never runs.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   start        one-cycle pulse; begins a load when not busy
//   rx_data      stream byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte (transfer = rx_valid & rx_ready)
//   imem_we      instruction memory write enable, one pulse per word
//   imem_addr    word address (index), zero-extended to 32 bits
//   imem_wdata   assembled instruction
//   cpu_hold     keep the CPU in reset while high
//   busy         load in progress
//   done         last load completed OK (level)
//   error        last load failed (level)
//   words_loaded number of words written in the current or last load
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SYNC   = 4'd1;
  localparam logic [3:0] S_CNT_HI = 4'd2;
  localparam logic [3:0] S_CNT_LO = 4'd3;
  localparam logic [3:0] S_DATA   = 4'd4;
  localparam logic [3:0] S_WRITE  = 4'd5;
  localparam logic [3:0] S_CHK    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  // Largest legal word count. The memory holds exactly 2^ADDR_W words.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  logic [3:0]      state_q, state_d;
  logic            rx_ready_q, rx_ready_d;
  logic            imem_we_q, imem_we_d;
  logic [31:0]     imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [ADDR_W:0] words_q, words_d;
  logic [7:0]      chk_q, chk_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [23:0]     word_q, word_d;     // first three bytes of the current word
  logic [1:0]      byte_idx_q, byte_idx_d;

  logic            xfer;
  logic [15:0]     n_full;
  logic [16:0]     words_inc;

  // rx_ready is registered and reflects the current state, so a transfer
  // can be decoded from the registered copy without a combinational path.
  assign xfer      = rx_valid & rx_ready_q;
  assign n_full    = {cnt_q[15:8], rx_data};
  assign words_inc = 17'(words_q) + 17'd1;

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    words_d      = words_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_SYNC;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = '0;
          chk_d      = 8'h00;
          busy_d     = 1'b1;
          cpu_hold_d = 1'b1;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_CNT_HI;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_d[15:8] = rx_data;
          state_d     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_d = n_full;
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (n_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d     = {word_q[15:0], rx_data};
          chk_d      = chk_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The fourth byte completes the word. The write is issued from
            // the registered outputs during the one-cycle WRITE state.
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = 32'(words_q);
            imem_wdata_d = {word_q, rx_data};
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + (ADDR_W + 1)'(1);
        if (words_inc == {1'b0, cnt_q}) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (rx_data == chk_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_SYNC)   || (state_d == S_CNT_HI) ||
                 (state_d == S_CNT_LO) || (state_d == S_DATA)   ||
                 (state_d == S_CHK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
      chk_q        <= 8'h00;
      cnt_q        <= 16'h0000;
      word_q       <= '0;
      byte_idx_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader.
// A frame-level reference model derives the expected writes and the final
// status from the byte list. Bytes are driven with optional random rx_valid
// gaps. A monitor records every accepted byte and every memory write.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  frame[$];
  logic [7:0]  xfer_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_words;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
      if (imem_we) begin
        got_addr.push_back(imem_addr);
        got_data.push_back(imem_wdata);
        check("rx_ready_low_in_write", 64'(rx_ready), 64'(0));
      end
    end
  end

  // Reference model: interprets the whole frame by its rules.
  function automatic void build_model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    x = 8'h00;
    if (frame[0] != 8'hA5) begin
      exp_err = 1'b1;
      return;
    end
    n = int'({frame[1], frame[2]});
    if (n > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {frame[3+4*i], frame[4+4*i], frame[5+4*i], frame[6+4*i]};
      exp_addr.push_back(32'(i));
      exp_data.push_back(w);
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    exp_words = n;
    exp_done  = (frame[3+4*n] == x);
    exp_err   = !exp_done;
  endfunction

  function automatic void make_frame(int n, bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
    frame.push_back(corrupt ? ~x : x);
  endfunction

  function automatic void two_word_frame();
    frame = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h12, 8'h34, 8'h56, 8'h78, 8'h2A};
  endfunction

  // Called at posedge+2 and returns at posedge+2 after the byte is accepted.
  task automatic send_byte(logic [7:0] b, int max_gap, bit spam, output bit ok);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin @(posedge clk); #2; end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = spam;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_frame(string name, int max_gap, bit spam);
    bit ok;
    build_model();
    got_addr.delete();
    got_data.delete();
    xfer_q.delete();
    pulse_start();
    check({name, "_busy_after_start"}, 64'(busy), 64'(1));
    check({name, "_hold_after_start"}, 64'(cpu_hold), 64'(1));
    check({name, "_done_cleared"}, 64'(done), 64'(0));
    check({name, "_error_cleared"}, 64'(error), 64'(0));
    check({name, "_words_cleared"}, 64'(words_loaded), 64'(0));
    foreach (frame[i]) begin
      send_byte(frame[i], max_gap, spam, ok);
      check({name, "_byte_accepted"}, 64'(ok), 64'(1));
      if (!ok) break;
    end
    for (int i = 0; i < 50 && busy; i++) begin @(posedge clk); #2; end
    @(posedge clk); #2;
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_words_loaded"}, 64'(words_loaded), 64'(exp_words));
    check({name, "_rx_ready_idle"}, 64'(rx_ready), 64'(0));
    check({name, "_write_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    foreach (exp_addr[i]) begin
      if (i < got_addr.size()) begin
        check({name, "_waddr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
        check({name, "_wdata"}, 64'(got_data[i]), 64'(exp_data[i]));
      end
    end
    check({name, "_bytes_taken"}, 64'(xfer_q.size()), 64'(frame.size()));
    foreach (frame[i]) begin
      if (i < xfer_q.size()) check({name, "_byte_value"}, 64'(xfer_q[i]), 64'(frame[i]));
    end
    $display("frame %s: bytes=%0d writes=%0d done=%0b error=%0b words=%0d",
             name, frame.size(), got_addr.size(), done, error, words_loaded);
  endtask

  task automatic check_all_zero(string name);
    check({name, "_rx_ready"}, 64'(rx_ready), 64'(0));
    check({name, "_imem_we"}, 64'(imem_we), 64'(0));
    check({name, "_imem_addr"}, 64'(imem_addr), 64'(0));
    check({name, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
    check({name, "_cpu_hold"}, 64'(cpu_hold), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_error"}, 64'(error), 64'(0));
    check({name, "_words"}, 64'(words_loaded), 64'(0));
  endtask

  initial begin
    bit ok;
    // Power-on reset.
    #1;
    check_all_zero("reset");
    $display("reset: outputs checked");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    two_word_frame();
    run_frame("two_word", 0, 1'b0);

    two_word_frame();
    run_frame("backpressure", 5, 1'b0);

    frame = '{8'h5A};
    run_frame("bad_sync", 0, 1'b0);

    make_frame(3, 1'b0);
    run_frame("recover", 3, 1'b0);

    frame = '{8'hA5, 8'h01, 8'h01};
    run_frame("oversize", 2, 1'b0);

    frame = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame("bad_chk", 1, 1'b0);

    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("empty", 0, 1'b0);

    // Reset asserted between the two words of a load.
    two_word_frame();
    got_addr.delete();
    got_data.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send_byte(frame[i], 0, 1'b0, ok);
      check("midreset_byte_accepted", 64'(ok), 64'(1));
    end
    @(posedge clk); #2;
    check("midreset_first_write_count", 64'(got_addr.size()), 64'(1));
    check("midreset_words_before", 64'(words_loaded), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    $display("midreset: outputs checked after async reset");
    @(negedge clk);
    rst = 1'b0;

    two_word_frame();
    run_frame("after_reset", 3, 1'b1);

    // Randomized frames, some with a corrupted checksum.
    for (int k = 0; k < 6; k++) begin
      make_frame(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0));
      run_frame("random", int'($urandom_range(4, 0)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
